// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch unit feeding the decoder from instruction memory.
//   Keeps the program counter, issues word reads over a req/ack + rvalid handshake,
//   buffers returned words in an in-order prefetch FIFO and presents them with valid/ready.
//   A redirect flushes the FIFO, restarts at redirect_pc and drops stale in-flight responses.
// Ports:
//   clk_i, reset_n_i                   clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o            fetch request and word address
//   imem_ack_i                         request accepted this cycle
//   imem_rvalid_i, imem_rdata_i        in-order read response
//   inst_o, inst_pc_o, inst_valid_o    FIFO head towards the decoder
//   inst_ready_i                       decoder consumes the head
//   redirect_i, redirect_pc_i          flush and restart fetching at redirect_pc_i
//   fetch_fault_o                      misaligned redirect pending
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirects in a FAULT state;
//   otherwise the low two bits of redirect_pc_i are ignored and fetch_fault_o is 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_fault_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     aq_q        [FIFO_DEPTH];

    logic            req, ack, push, pop, misaligned;
    logic [31:0]     tgt_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt_pc        = redirect_pc_i;
    assign misaligned    = redirect_pc_i[1:0] != 2'b00;
    assign fetch_fault_o = state_q == FAULT;
`else
    assign tgt_pc        = redirect_pc_i & 32'hFFFF_FFFC;
    assign misaligned    = 1'b0;
    assign fetch_fault_o = 1'b0;
`endif

    // Credit counts stale in-flight requests too, so a push can never find the FIFO full.
    assign req  = (state_q == RUN) && !redirect_i &&
                  (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH));
    assign ack  = req && imem_ack_i;
    assign push = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign pop  = (count_q != '0) && inst_ready_i && !redirect_i;

    assign imem_req_o   = req;
    assign imem_addr_o  = pc_q;
    assign inst_o       = fifo_inst_q[rd_ptr_q];
    assign inst_pc_o    = fifo_pc_q[rd_ptr_q];
    assign inst_valid_o = count_q != '0;

    always_comb begin
        state_d    = redirect_i ? (misaligned ? FAULT : RUN) : (state_q == IDLE ? RUN : state_q);
        pc_d       = redirect_i ? tgt_pc : (ack ? pc_q + 32'd4 : pc_q);
        inflight_d = inflight_q + CW'(ack) - CW'(imem_rvalid_i);
        // Everything still outstanding after this cycle belongs to the old stream.
        discard_d  = redirect_i ? inflight_d :
                     (imem_rvalid_i && discard_q != '0) ? discard_q - CW'(1) : discard_q;
        count_d    = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = redirect_i ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d   = redirect_i ? '0 : wr_ptr_q + AW'(push);
        // The address queue tracks every issued request, stale or not, so it is never flushed.
        aq_wr_d    = aq_wr_q + AW'(ack);
        aq_rd_d    = aq_rd_q + AW'(imem_rvalid_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q       <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                aq_q[i]        <= '0;
            end
        end else begin
            if (ack) aq_q[aq_wr_q] <= pc_q;
            if (push) begin
                fifo_inst_q[wr_ptr_q] <= imem_rdata_i;
                fifo_pc_q[wr_ptr_q]   <= aq_q[aq_rd_q];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a stream-level model.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        imem_req_o, imem_ack_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = '0;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o, inst_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        fetch_fault_o;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .fetch_fault_o(fetch_fault_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int ack_pct = 100, rsp_pct = 100, rdy_pct = 100;
    int cyc = 0, epoch = 0, buffered = 0;
    bit running = 1'b0, fault = 1'b0, last_valid = 1'b0;
    logic [31:0] exp_pc = RPC, exp_req_pc = RPC;
    logic [31:0] maddr[$];
    int          mep[$];
    int          mcyc[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // One clock cycle: drive inputs just after the falling edge, check, advance the model.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit exp_req, fire, pop, rv;
        logic [31:0] tgt;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        inst_ready_i  = $urandom_range(99) < rdy_pct;
        imem_ack_i    = $urandom_range(99) < ack_pct;
        rv = (maddr.size() > 0) && (mcyc[0] < cyc) && ($urandom_range(99) < rsp_pct);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mdata(maddr[0]) : 32'hDEAD_BEEF;
        #1;
        exp_req = running && !fault && !redir && (maddr.size() + buffered < DEPTH);
        total++;
        if (imem_req_o !== exp_req) begin
            bad++; $display("FAIL req cyc=%0d: got %b expected %b", cyc, imem_req_o, exp_req);
        end
        if (exp_req) begin
            total++;
            if (imem_addr_o !== exp_req_pc) begin
                bad++; $display("FAIL addr cyc=%0d: got %h expected %h", cyc, imem_addr_o, exp_req_pc);
            end
        end
        total++;
        if (inst_valid_o !== (buffered > 0)) begin
            bad++; $display("FAIL valid cyc=%0d: got %b expected %b", cyc, inst_valid_o, buffered > 0);
        end
        if (buffered > 0) begin
            total++;
            if (inst_pc_o !== exp_pc || inst_o !== mdata(exp_pc)) begin
                bad++; $display("FAIL head cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                                cyc, inst_pc_o, inst_o, exp_pc, mdata(exp_pc));
            end
        end
        total++;
        if (fetch_fault_o !== fault) begin
            bad++; $display("FAIL fault cyc=%0d: got %b expected %b", cyc, fetch_fault_o, fault);
        end
        last_valid = inst_valid_o;
        fire = exp_req && imem_ack_i;
        pop  = (buffered > 0) && inst_ready_i && !redir;
        if (rv) begin
            if (mep[0] == epoch && !redir) buffered++;
            void'(maddr.pop_front()); void'(mep.pop_front()); void'(mcyc.pop_front());
        end
        if (pop) begin
            pop_log.push_back(inst_pc_o);
            buffered--;
            exp_pc += 32'd4;
        end
        if (fire) begin
            maddr.push_back(exp_req_pc); mep.push_back(epoch); mcyc.push_back(cyc);
            exp_req_pc += 32'd4;
        end
        if (redir) begin
            tgt        = ALIGN ? rpc : (rpc & 32'hFFFF_FFFC);
            fault      = ALIGN && (rpc[1:0] != 2'b00);
            epoch++;
            buffered   = 0;
            exp_pc     = tgt;
            exp_req_pc = tgt;
        end
        running = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        #1;
        total++; if (imem_req_o !== 1'b0)   begin bad++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
        total++; if (imem_addr_o !== RPC)   begin bad++; $display("FAIL rst_addr: got %h expected %h", imem_addr_o, RPC); end
        total++; if (inst_o !== 32'h0)      begin bad++; $display("FAIL rst_inst: got %h expected 0", inst_o); end
        total++; if (inst_pc_o !== 32'h0)   begin bad++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc_o); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
        total++; if (fetch_fault_o !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b expected 0", fetch_fault_o); end
        maddr.delete(); mep.delete(); mcyc.delete();
        buffered = 0; epoch++; running = 1'b0; fault = 1'b0;
        exp_pc = RPC; exp_req_pc = RPC;
        redirect_i = 1'b0; imem_ack_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    task automatic test_stream();
        ack_pct = 100; rsp_pct = 100; rdy_pct = 100;
        pop_log.delete();
        repeat (20) cycle(1'b0, '0);
        total++; if (pop_log.size() != 17) begin bad++; $display("FAIL stream_rate: got %0d pops expected 17", pop_log.size()); end
        total++; if (pop_log[0] !== 32'h100) begin bad++; $display("FAIL stream_0: got %h expected 100", pop_log[0]); end
        total++; if (pop_log[1] !== 32'h104) begin bad++; $display("FAIL stream_1: got %h expected 104", pop_log[1]); end
        total++; if (pop_log[2] !== 32'h108) begin bad++; $display("FAIL stream_2: got %h expected 108", pop_log[2]); end
    endtask

    task automatic test_backpressure();
        rdy_pct = 0;
        repeat (10) cycle(1'b0, '0);
        #1;
        total++; if (imem_req_o !== 1'b0)   begin bad++; $display("FAIL bp_req: got %b expected 0", imem_req_o); end
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b expected 1", inst_valid_o); end
        rdy_pct = 100;
        pop_log.delete();
        repeat (10) cycle(1'b0, '0);
        total++; if (pop_log.size() != 10) begin bad++; $display("FAIL bp_release: got %0d pops expected 10", pop_log.size()); end
    endtask

    task automatic test_redirect_inflight();
        rsp_pct = 0;
        for (int i = 0; i < 8 && maddr.size() < 2; i++) cycle(1'b0, '0);
        cycle(1'b1, 32'h400);
        rsp_pct = 100;
        pop_log.delete();
        repeat (12) cycle(1'b0, '0);
        total++; if (pop_log[0] !== 32'h400) begin bad++; $display("FAIL redir_first: got %h expected 400", pop_log[0]); end
        total++; if (pop_log[1] !== 32'h404) begin bad++; $display("FAIL redir_second: got %h expected 404", pop_log[1]); end
    endtask

    task automatic test_same_cycle();
        repeat (6) cycle(1'b0, '0);
        cycle(1'b1, 32'h600);
        total++; if (last_valid !== 1'b1) begin bad++; $display("FAIL same_valid_before: got %b expected 1", last_valid); end
        #1;
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL same_valid_after: got %b expected 0", inst_valid_o); end
        pop_log.delete();
        repeat (8) cycle(1'b0, '0);
        total++; if (pop_log[0] !== 32'h600) begin bad++; $display("FAIL same_first: got %h expected 600", pop_log[0]); end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 32'hFFFF_FFF8);
        pop_log.delete();
        repeat (10) cycle(1'b0, '0);
        total++; if (pop_log[0] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_0: got %h expected fffffff8", pop_log[0]); end
        total++; if (pop_log[1] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_1: got %h expected fffffffc", pop_log[1]); end
        total++; if (pop_log[2] !== 32'h0000_0000) begin bad++; $display("FAIL wrap_2: got %h expected 00000000", pop_log[2]); end
    endtask

    task automatic test_misaligned();
        cycle(1'b1, 32'h402);
        pop_log.delete();
        repeat (6) cycle(1'b0, '0);
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (fetch_fault_o !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b expected 1", fetch_fault_o); end
        total++; if (imem_req_o !== 1'b0)    begin bad++; $display("FAIL mis_req: got %b expected 0", imem_req_o); end
        total++; if (pop_log.size() != 0)    begin bad++; $display("FAIL mis_pops: got %0d expected 0", pop_log.size()); end
`else
        total++; if (fetch_fault_o !== 1'b0) begin bad++; $display("FAIL mis_fault: got %b expected 0", fetch_fault_o); end
        total++; if (pop_log[0] !== 32'h400) begin bad++; $display("FAIL mis_first: got %h expected 400", pop_log[0]); end
`endif
        cycle(1'b1, 32'h500);
        pop_log.delete();
        repeat (8) cycle(1'b0, '0);
        #1;
        total++; if (fetch_fault_o !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b expected 0", fetch_fault_o); end
        total++; if (pop_log[0] !== 32'h500) begin bad++; $display("FAIL mis_resume: got %h expected 500", pop_log[0]); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        ack_pct = 70; rsp_pct = 60; rdy_pct = 70;
        pop_log.delete();
        for (int i = 0; i < 2000; i++) begin
            rpc = $urandom & (($urandom_range(9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            cycle($urandom_range(99) < 3, rpc);
        end
        cycle(1'b1, 32'h800);
        ack_pct = 100; rsp_pct = 100; rdy_pct = 100;
        repeat (10) cycle(1'b0, '0);
        total++; if (pop_log.size() < 200) begin bad++; $display("FAIL rand_progress: got %0d pops expected >= 200", pop_log.size()); end
    endtask

    task automatic test_reset_midrun();
        repeat (5) cycle(1'b0, '0);
        test_reset();
        pop_log.delete();
        repeat (10) cycle(1'b0, '0);
        total++; if (pop_log[0] !== RPC) begin bad++; $display("FAIL midrst_first: got %h expected %h", pop_log[0], RPC); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_same_cycle();
        test_wrap();
        test_misaligned();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
